ram_wb_arbiter: RTL and testbench
=================================

Name: ram_wb_arbiter

Overview:
- Two-master, single-slave Wishbone-style arbiter for the shared test RAM port.
- The PicoBlaze-based RAM test controller and a second bus master (DMA/debug) each issue single-beat cycles. The arbiter serialises them onto the one RAM slave port.
- Uses fair round-robin arbitration, holds the grant for a whole cycle, and forces termination of any cycle the slave never acknowledges (watchdog).

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles a granted transfer may wait for slave ack before a forced abort; legal range 2..65535.
- COUNTER_WIDTH, 16: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- pinClock  in  1  single system clock, rising edge.
- pinResetN  in  1  asynchronous, active-low reset.
- pinM0CycleStrobe  in  1  master 0 request; held high until its ack.
- pinM0WriteEnable  in  1  master 0 write (1) / read (0).
- pinM0Address  in  32  master 0 address.
- pinM0WriteData  in  32  master 0 write data.
- pinM0ReadData  out  32  read data returned to master 0.
- pinM0Ack  out  1  single-cycle ack to master 0.
- pinM1CycleStrobe, pinM1WriteEnable, pinM1Address, pinM1WriteData, pinM1ReadData, pinM1Ack: same as the master 0 ports, for master 1.
- pinWbCycleStrobe  out  1  to RAM slave.
- pinWbWriteEnable  out  1  to RAM slave.
- pinWbAddress  out  32  to RAM slave.
- pinWbWriteData  out  32  to RAM slave.
- pinWbReadData  in  32  from RAM slave.
- pinWbAck  in  1  from RAM slave.
- pinTimeout  out  1  one-cycle pulse when a transfer is aborted by the watchdog.
- pinTimeoutCount  out  8  saturating count of aborts since reset.

Behaviour:
- Reset (pinResetN low, asynchronous):
  - state=IDLE, lastGrant=1 (so master 0 wins the first tie), watchdog=0, pinTimeoutCount=0.
  - All outputs 0 while in reset and in IDLE.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - Only M0 requesting -> GRANT0. Only M1 requesting -> GRANT1.
  - Both requesting -> grant the master other than lastGrant.
  - Neither requesting -> stay in IDLE.
  - Decision registered; watchdog cleared on entry to a GRANTx state.
- GRANTx:
  - pinWbCycleStrobe=1; pinWbWriteEnable, pinWbAddress and pinWbWriteData are driven combinationally from master x.
  - Non-granted master sees ack=0 and readData=0.
- Latency: request sampled high at edge N -> slave strobe high from cycle N+1. Minimum transfer = 2 cycles (zero-wait slave).
- Slave ack in GRANTx:
  - pinMxAck=pinWbAck, combinational in the same cycle.
  - pinMxReadData=pinWbReadData, valid only while ack is high.
  - Next state IDLE; lastGrant=x.
  - There is always one IDLE cycle between grants; no back-to-back pipelining.
- Watchdog:
  - Increments every GRANTx cycle without ack.
  - When watchdog == TIMEOUT_CYCLES-1 and no ack: pinMxAck=1, pinMxReadData=32'hDEADBEEF, pinTimeout=1 for that cycle.
  - pinTimeoutCount increments, saturating at 255. Next state IDLE; lastGrant=x.
  - Ack and timeout in the same cycle -> ack wins: normal data, no pulse, count unchanged.
- Master drops its request while granted (protocol violation): arbiter completes nonetheless.
  - Slave strobe stays high until ack or timeout; the master's ack is still issued.
  - Address/data follow the master's current pins (undefined contract).
- Slave ack in IDLE (stray): ignored; no master ack.
- Reset asserted mid-transfer: immediate return to IDLE, strobe drops asynchronously, no ack issued.
- Widths: watchdog is COUNTER_WIDTH bits and never wraps, because it is cleared on leaving GRANTx.

Decomposition:
- Shared package ram_wb_pkg holds:
  - state encoding constants (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2);
  - TIMEOUT_READ_DATA=32'hDEADBEEF;
  - the bus field widths (address 32, data 32).
- One natural sub-module, ram_wb_watchdog: the counter plus expiry comparator plus saturating abort counter. Inputs are enable/clear/ack; outputs are expire and count.
- The arbiter FSM and the mux live in ram_wb_arbiter.

Test Plan:
- Single M0 read, addr 0x00000010, slave acks 2 cycles after strobe with data 0x12345678 -> pinWbCycleStrobe high 3 cycles, pinM0Ack pulse with data 0x12345678, pinM1Ack stays 0.
- M0 and M1 request in the same cycle from reset, zero-wait slave -> M0 served first, one IDLE cycle, then M1. Both held continuously -> grants alternate M0, M1, M0, M1.
- M1 write, addr 0x00000400, data 0xCAFEF00D -> slave sees writeEnable=1 and exact address/data for the whole grant; M0 pins have no effect.
- Slave never acks, TIMEOUT_CYCLES=8, M0 read -> strobe high 8 cycles, pinM0Ack plus pinTimeout on the 8th with data 0xDEADBEEF, pinTimeoutCount=1. Repeated 300 times -> count saturates at 255.
- Slave ack coincides with the expiry cycle -> real read data delivered, no timeout pulse, count unchanged.
- pinResetN pulled low mid-grant (cycle 2 of a pending transfer) -> strobe 0 immediately, no ack. After release, the first request is granted normally with M0 priority on a tie.

Source files
------------

// File: rtl/ram_wb_pkg.sv
// Shared definitions for the two-master RAM Wishbone arbiter: state encoding,
// bus field widths and the data word returned on a watchdog abort.
package ram_wb_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int ABORT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] TIMEOUT_READ_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/ram_wb_watchdog.sv
// Per-transfer wait counter with expiry detection, plus a saturating count of
// transfers that were forcibly terminated.
module ram_wb_watchdog
  import ram_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNTER_WIDTH  = 16
) (
  input  logic                   pinClock,
  input  logic                   pinResetN,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   ack,
  output logic                   expire,
  output logic [ABORT_CNT_W-1:0] count
);

  localparam logic [COUNTER_WIDTH-1:0] LIMIT = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [COUNTER_WIDTH-1:0] waitCount;

  function automatic logic [ABORT_CNT_W-1:0] sat_inc(input logic [ABORT_CNT_W-1:0] value);
    return (value == {ABORT_CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

  // A real ack in the expiry cycle takes precedence over the abort.
  assign expire = enable && !ack && (waitCount == LIMIT);

  always_ff @(posedge pinClock or negedge pinResetN) begin
    if (!pinResetN) begin
      waitCount <= '0;
    end else if (clear || ack || expire) begin
      waitCount <= '0;
    end else if (enable) begin
      waitCount <= waitCount + 1'b1;
    end
  end

  always_ff @(posedge pinClock or negedge pinResetN) begin
    if (!pinResetN) begin
      count <= '0;
    end else if (expire) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/ram_wb_arbiter.sv
// Round-robin arbiter serialising two single-beat Wishbone masters onto one
// RAM slave port, with a watchdog that force-terminates unacknowledged cycles.
module ram_wb_arbiter
  import ram_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNTER_WIDTH  = 16
) (
  input  logic                   pinClock,
  input  logic                   pinResetN,
  input  logic                   pinM0CycleStrobe,
  input  logic                   pinM0WriteEnable,
  input  logic [ADDR_W-1:0]      pinM0Address,
  input  logic [DATA_W-1:0]      pinM0WriteData,
  output logic [DATA_W-1:0]      pinM0ReadData,
  output logic                   pinM0Ack,
  input  logic                   pinM1CycleStrobe,
  input  logic                   pinM1WriteEnable,
  input  logic [ADDR_W-1:0]      pinM1Address,
  input  logic [DATA_W-1:0]      pinM1WriteData,
  output logic [DATA_W-1:0]      pinM1ReadData,
  output logic                   pinM1Ack,
  output logic                   pinWbCycleStrobe,
  output logic                   pinWbWriteEnable,
  output logic [ADDR_W-1:0]      pinWbAddress,
  output logic [DATA_W-1:0]      pinWbWriteData,
  input  logic [DATA_W-1:0]      pinWbReadData,
  input  logic                   pinWbAck,
  output logic                   pinTimeout,
  output logic [ABORT_CNT_W-1:0] pinTimeoutCount
);

  state_t            state;
  state_t            stateNext;
  logic              lastGrant;
  logic              lastGrantNext;
  logic              granted;
  logic              expire;
  logic              transferDone;
  logic [DATA_W-1:0] respData;

  assign granted      = (state == GRANT0) || (state == GRANT1);
  assign transferDone = granted && (pinWbAck || expire);
  assign respData     = pinWbAck ? pinWbReadData :
                        (expire ? TIMEOUT_READ_DATA : '0);

  ram_wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .COUNTER_WIDTH  (COUNTER_WIDTH)
  ) u_watchdog (
    .pinClock  (pinClock),
    .pinResetN (pinResetN),
    .enable    (granted),
    .clear     (state == IDLE),
    .ack       (pinWbAck),
    .expire    (expire),
    .count     (pinTimeoutCount)
  );

  always_ff @(posedge pinClock or negedge pinResetN) begin
    if (!pinResetN) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
    end
  end

  // A tie goes to whichever master was not served last.
  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    case (state)
      IDLE: begin
        if (pinM0CycleStrobe && pinM1CycleStrobe) begin
          stateNext = lastGrant ? GRANT0 : GRANT1;
        end else if (pinM0CycleStrobe) begin
          stateNext = GRANT0;
        end else if (pinM1CycleStrobe) begin
          stateNext = GRANT1;
        end
      end
      GRANT0: begin
        if (transferDone) begin
          stateNext     = IDLE;
          lastGrantNext = 1'b0;
        end
      end
      GRANT1: begin
        if (transferDone) begin
          stateNext     = IDLE;
          lastGrantNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    pinWbCycleStrobe = 1'b0;
    pinWbWriteEnable = 1'b0;
    pinWbAddress     = '0;
    pinWbWriteData   = '0;
    pinM0Ack         = 1'b0;
    pinM0ReadData    = '0;
    pinM1Ack         = 1'b0;
    pinM1ReadData    = '0;
    pinTimeout       = expire;
    case (state)
      GRANT0: begin
        pinWbCycleStrobe = 1'b1;
        pinWbWriteEnable = pinM0WriteEnable;
        pinWbAddress     = pinM0Address;
        pinWbWriteData   = pinM0WriteData;
        pinM0Ack         = transferDone;
        pinM0ReadData    = respData;
      end
      GRANT1: begin
        pinWbCycleStrobe = 1'b1;
        pinWbWriteEnable = pinM1WriteEnable;
        pinWbAddress     = pinM1Address;
        pinWbWriteData   = pinM1WriteData;
        pinM1Ack         = transferDone;
        pinM1ReadData    = respData;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Scoreboard bench for ram_wb_arbiter: random masters and a random-latency
// slave, checked against a transaction-level arbitration and response model.
module tb_ram_wb_arbiter;
  import ram_wb_pkg::*;

  localparam int T = 8;

  typedef struct {
    logic [31:0] data;
    bit          timeout;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_cyc   [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic        m_ack   [2];
  logic        wb_cyc, wb_we, wb_ack, to_pulse;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic [7:0]  to_cnt;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   slave_mode = 1;
  int   fixed_w = 0;

  ram_wb_arbiter #(.TIMEOUT_CYCLES(T), .COUNTER_WIDTH(16)) dut (
    .pinClock         (clk),
    .pinResetN        (rst_n),
    .pinM0CycleStrobe (m_cyc[0]),
    .pinM0WriteEnable (m_we[0]),
    .pinM0Address     (m_addr[0]),
    .pinM0WriteData   (m_wdata[0]),
    .pinM0ReadData    (m_rdata[0]),
    .pinM0Ack         (m_ack[0]),
    .pinM1CycleStrobe (m_cyc[1]),
    .pinM1WriteEnable (m_we[1]),
    .pinM1Address     (m_addr[1]),
    .pinM1WriteData   (m_wdata[1]),
    .pinM1ReadData    (m_rdata[1]),
    .pinM1Ack         (m_ack[1]),
    .pinWbCycleStrobe (wb_cyc),
    .pinWbWriteEnable (wb_we),
    .pinWbAddress     (wb_addr),
    .pinWbWriteData   (wb_wdata),
    .pinWbReadData    (wb_rdata),
    .pinWbAck         (wb_ack),
    .pinTimeout       (to_pulse),
    .pinTimeoutCount  (to_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Master x: raise a request, hold until acked, then drop and scramble pins.
  task automatic m_xfer(input int m, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    bit got;
    got        = 1'b0;
    lat        = 0;
    m_cyc[m]   = 1'b1;
    m_we[m]    = we;
    m_addr[m]  = addr;
    m_wdata[m] = wdata;
    while (!got && lat < 64) begin
      @(negedge clk);
      lat++;
      got = m_ack[m];
    end
    chk($sformatf("m%0d_ack_received", m), 96'(got), 96'(1));
    @(posedge clk);
    #1;
    m_cyc[m]   = 1'b0;
    m_we[m]    = 1'($urandom);
    m_addr[m]  = $urandom;
    m_wdata[m] = $urandom;
  endtask

  // Slave: picks a wait per transfer and pushes the response the masters must see.
  initial begin : slave
    bit          active;
    bit          done;
    int          cnt;
    int          w;
    logic [31:0] d;
    active = 0; done = 0; cnt = 0; w = 0; d = '0;
    wb_ack = 1'b0;
    wb_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        active = 0; done = 0; wb_ack = 1'b0; wb_rdata = '0;
      end else begin
        if (done) begin
          active = 0;
          done = 0;
        end
        if (wb_cyc) begin
          if (!active) begin
            active = 1;
            cnt = 0;
            w = (slave_mode == 0) ? int'($urandom_range(0, T + 1)) :
                (slave_mode == 1) ? fixed_w : T;
            d = slave_data(wb_addr);
            if (w < T) sb.push_back('{data: d, timeout: 1'b0, cycles: w + 1});
            else       sb.push_back('{data: 32'hDEADBEEF, timeout: 1'b1, cycles: T});
          end
          cnt++;
          wb_ack   = (w < T) && (cnt == w + 1);
          wb_rdata = wb_ack ? d : $urandom;
          done     = wb_ack || (cnt == T);
        end else begin
          wb_ack   = (slave_mode == 0) && ($urandom_range(0, 3) == 0);
          wb_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: round-robin grant model, pass-through, and response scoreboard.
  initial begin : monitor
    bit         prev_strobe;
    bit         prev_done;
    logic [1:0] prev_req;
    int         g;
    int         last;
    int         gcyc;
    int         model_cnt;
    exp_t       e;
    prev_strobe = 0; prev_done = 0; prev_req = '0;
    g = 0; last = 1; gcyc = 0; model_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        prev_strobe = 0; prev_done = 0; prev_req = '0;
        last = 1; gcyc = 0; model_cnt = 0;
      end else begin
        if (prev_done) chk("idle_gap_after_transfer", 96'(wb_cyc), 96'(0));
        if (wb_cyc) begin
          if (!prev_strobe) begin
            chk("grant_had_request", 96'(|prev_req), 96'(1));
            g = (prev_req == 2'b11) ? ((last == 1) ? 0 : 1) : (prev_req[1] ? 1 : 0);
            last = g;
            gcyc = 0;
          end
          gcyc++;
          chk("bus_pass_through", {31'd0, wb_we, wb_addr, wb_wdata},
              {31'd0, m_we[g], m_addr[g], m_wdata[g]});
          chk("other_master_quiet", 96'({m_ack[1-g], m_rdata[1-g]}), 96'(0));
          if (m_ack[g]) begin
            if (sb.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_ack: master %0d acked with no transfer pending", g);
            end else begin
              e = sb.pop_front();
              chk("read_data", 96'(m_rdata[g]), 96'(e.data));
              chk("timeout_pulse", 96'(to_pulse), 96'(e.timeout));
              chk("grant_length", 96'(gcyc), 96'(e.cycles));
              chk("timeout_count", 96'(to_cnt), 96'(model_cnt));
              if (e.timeout && model_cnt < 255) model_cnt++;
            end
            prev_done = 1;
          end else begin
            chk("no_timeout_pulse", 96'(to_pulse), 96'(0));
            prev_done = 0;
          end
        end else begin
          if (prev_strobe) chk("grant_completed", 96'(prev_done), 96'(1));
          chk("idle_outputs", {m_ack[0], m_ack[1], to_pulse, m_rdata[0], m_rdata[1]}, 96'(0));
          chk("idle_count", 96'(to_cnt), 96'(model_cnt));
          prev_done = 0;
        end
        prev_strobe = wb_cyc;
        prev_req = {m_cyc[1], m_cyc[0]};
      end
    end
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin : main
    int lat;
    int lat0;
    int lat1;
    bit seen;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
    end
    m_cyc[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_slave_side", {wb_cyc, wb_we, wb_addr, wb_wdata}, 96'(0));
    chk("reset_master_side", {m_ack[0], m_ack[1], to_pulse, to_cnt, m_rdata[0], m_rdata[1]}, 96'(0));
    m_cyc[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    slave_mode = 1; fixed_w = 2;
    m_xfer(0, 1'b0, 32'h0000_0010, $urandom, lat);
    chk("m0_read_latency", 96'(lat), 96'(4));

    m_we[0] = 1'b1; m_addr[0] = 32'h0000_0400; m_wdata[0] = 32'h1111_2222;
    m_xfer(1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, lat);
    chk("m1_write_latency", 96'(lat), 96'(4));

    fixed_w = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) m_xfer(0, 1'($urandom), 32'h100 + 32'(i), $urandom, lat0);
      end
      begin
        for (int i = 0; i < 4; i++) m_xfer(1, 1'($urandom), 32'h200 + 32'(i), $urandom, lat1);
      end
    join

    fixed_w = T - 1;
    m_xfer(0, 1'b0, 32'h0000_0020, $urandom, lat);
    chk("ack_at_expiry_latency", 96'(lat), 96'(T + 1));

    slave_mode = 2;
    m_xfer(0, 1'b0, 32'h0000_0030, $urandom, lat);
    chk("timeout_latency", 96'(lat), 96'(T + 1));
    chk("count_after_first_timeout", 96'(to_cnt), 96'(1));

    slave_mode = 1; fixed_w = 3;
    m_cyc[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h0000_0040;
    seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      seen = wb_cyc;
    end
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b0;
    m_addr[0] = $urandom;
    seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      seen = m_ack[0];
    end
    chk("dropped_request_still_acked", 96'(seen), 96'(1));
    @(posedge clk);
    #1;

    slave_mode = 0;
    fork
      begin
        int k;
        for (int i = 0; i < 30; i++) begin
          k = int'($urandom_range(0, 3));
          if (k > 0) begin
            repeat (k) @(posedge clk);
            #1;
          end
          m_xfer(0, 1'($urandom), $urandom, $urandom, lat0);
        end
      end
      begin
        int k;
        for (int i = 0; i < 30; i++) begin
          k = int'($urandom_range(0, 3));
          if (k > 0) begin
            repeat (k) @(posedge clk);
            #1;
          end
          m_xfer(1, 1'($urandom), $urandom, $urandom, lat1);
        end
      end
    join

    slave_mode = 2;
    for (int i = 0; i < 300; i++) m_xfer(0, 1'b0, $urandom, $urandom, lat);
    chk("count_saturated", 96'(to_cnt), 96'(255));

    m_cyc[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h0000_0050;
    seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      seen = wb_cyc;
    end
    chk("grant_before_reset", 96'(seen), 96'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_drops_strobe", 96'({wb_cyc, m_ack[0], m_ack[1]}), 96'(0));
    chk("reset_clears_count", 96'(to_cnt), 96'(0));
    m_cyc[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    slave_mode = 1; fixed_w = 1;
    rst_n = 1'b1;
    fork
      m_xfer(0, 1'b0, 32'h0000_0060, $urandom, lat0);
      m_xfer(1, 1'b0, 32'h0000_0070, $urandom, lat1);
    join
    chk("post_reset_m0_first", 96'(lat0), 96'(3));
    chk("post_reset_m1_second", 96'(lat1), 96'(6));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
